// File: rtl/block_check_sched_pkg.sv
// Shared definitions for the block-checker scheduler: FSM encoding, the ASCII
// space constant used by the checker, and the round-robin pointer step.
package block_check_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_SETTLE = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [7:0] SPACE = 8'd32;

    // Index following cur in a ring of n requesters.
    function automatic int rr_next(input int cur, input int n);
        if (cur >= n - 32'sd1) begin
            return 32'sd0;
        end else begin
            return cur + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/block_check_sched_if.sv
// Bundle of requester, checker and verdict signals around the scheduler.
interface block_check_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LEN_W = 16
);
    import block_check_sched_pkg::*;

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_char;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               chk_clear;
    logic               chk_valid;
    logic [7:0]         chk_char;
    logic               chk_result;
    logic               resp_valid;
    logic [ID_W-1:0]    resp_id;
    logic               resp_ok;
    logic [LEN_W-1:0]   resp_len;
    logic               busy;

    modport slave (
        input  req_valid, req_char, req_last, chk_result,
        output req_ready, chk_clear, chk_valid, chk_char,
               resp_valid, resp_id, resp_ok, resp_len, busy
    );

    modport master (
        output req_valid, req_char, req_last, chk_result,
        input  req_ready, chk_clear, chk_valid, chk_char,
               resp_valid, resp_id, resp_ok, resp_len, busy
    );

endinterface

// File: rtl/block_check_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module block_check_sched_rr_arbiter
    import block_check_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_id,
    output logic             o_any
);

    // Cyclic search starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = {N_REQ{1'b0}};
        o_id    = {ID_W{1'b0}};
        o_any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int              w_slot;
            logic [ID_W-1:0] w_idx;
            w_slot = int'(i_ptr) + k;
            if (w_slot >= N_REQ) begin
                w_slot = w_slot - N_REQ;
            end else begin
                w_slot = w_slot;
            end
            w_idx = ID_W'(w_slot);
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/block_check_sched.sv
// Time-shares one begin/end checker among N_REQ char-stream requesters, one
// whole message at a time, and reports a tagged per-message verdict.
module block_check_sched
    import block_check_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    block_check_sched_if.slave bus
);

    logic [N_REQ-1:0] w_arb_grant;
    logic [ID_W-1:0]  w_arb_id;
    logic             w_arb_any;

    state_t           r_state;
    logic [ID_W-1:0]  r_grant;
    logic [N_REQ-1:0] r_grant_oh;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic             r_chk_clear;
    logic             r_resp_valid;
    logic [ID_W-1:0]  r_resp_id;
    logic             r_resp_ok;
    logic [LEN_W-1:0] r_resp_len;

    logic             w_streaming;
    logic             w_accept;
    logic             w_last;
    logic [N_REQ-1:0] w_ready;
    logic [7:0]       w_char;

    block_check_sched_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_id    (w_arb_id),
        .o_any   (w_arb_any)
    );

    // Only the granted requester can be accepted, and only while streaming.
    always_comb begin
        w_streaming = (r_state == ST_STREAM);
        w_accept    = w_streaming & (|(bus.req_valid & r_grant_oh));
        w_last      = |(bus.req_last & r_grant_oh);
        if (w_streaming) begin
            w_char = bus.req_char[{r_grant, 3'b000} +: 8];
        end else begin
            w_char = 8'd0;
        end
        if (w_accept) begin
            w_ready = r_grant_oh;
        end else begin
            w_ready = {N_REQ{1'b0}};
        end
    end

    // Message scheduler; SETTLE exists so chk_result reflects the last char.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= {ID_W{1'b0}};
            r_grant_oh   <= {N_REQ{1'b0}};
            r_rr_ptr     <= {ID_W{1'b0}};
            r_len        <= {LEN_W{1'b0}};
            r_ovf        <= 1'b0;
            r_chk_clear  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= {ID_W{1'b0}};
            r_resp_ok    <= 1'b0;
            r_resp_len   <= {LEN_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (w_arb_any) begin
                        r_grant     <= w_arb_id;
                        r_grant_oh  <= w_arb_grant;
                        r_chk_clear <= 1'b1;
                        r_state     <= ST_CLEAR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    r_chk_clear <= 1'b0;
                    r_len       <= {LEN_W{1'b0}};
                    r_ovf       <= 1'b0;
                    r_state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        if (r_len == {LEN_W{1'b1}}) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_len <= r_len + {{(LEN_W-1){1'b0}}, 1'b1};
                        end
                        if (w_last) begin
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_SETTLE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_id    <= r_grant;
                    r_resp_ok    <= bus.chk_result & ~r_ovf;
                    r_resp_len   <= r_len;
                    r_state      <= ST_REPORT;
                end
                ST_REPORT: begin
                    r_resp_valid <= 1'b0;
                    r_rr_ptr     <= ID_W'(rr_next(int'(r_grant), N_REQ));
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_chk_clear  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.chk_clear  = r_chk_clear;
    assign bus.chk_valid  = w_accept;
    assign bus.chk_char   = w_char;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_ok    = r_resp_ok;
    assign bus.resp_len   = r_resp_len;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_block_check_sched.sv
// Scoreboard bench for block_check_sched: directed messages with a begin/end
// checker model; a monitor pops expected chars and verdicts as the DUT emits them.
module tb_block_check_sched;
    import block_check_sched_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LW  = 16;

    typedef struct {
        int id;
        bit ok;
        int len;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    block_check_sched_if #(.N_REQ(N), .ID_W(IDW), .LEN_W(LW)) bus ();
    block_check_sched_if #(.N_REQ(2), .ID_W(1), .LEN_W(3))    bus2 ();

    block_check_sched #(.N_REQ(N), .ID_W(IDW), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    block_check_sched #(.N_REQ(2), .ID_W(1), .LEN_W(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    int    clears = 0;
    int    overlaps = 0;
    int    last_acc [N];
    resp_t resp_q [$];
    resp_t resp2_q [$];
    byte   chk_q [$];
    string msg2 = "begin end";

    always @(posedge clk) cyc <= cyc + 1;

    // Reference begin/end checker: words split on SPACE, result is combinational
    // over the words seen so far plus the pending word.
    logic [39:0] m_word_r;
    int          m_wlen_r;
    int          m_depth_r;
    logic        m_neg_r;
    logic        m_pb;
    logic        m_pe;

    always @(posedge clk or posedge reset) begin
        if (reset || bus.chk_clear) begin
            m_word_r  <= '0;
            m_wlen_r  <= 0;
            m_depth_r <= 0;
            m_neg_r   <= 1'b0;
        end else if (bus.chk_valid) begin
            if (bus.chk_char == SPACE) begin
                if (m_wlen_r == 5 && m_word_r == "begin") begin
                    m_depth_r <= m_depth_r + 1;
                end else if (m_wlen_r == 3 && m_word_r[23:0] == "end") begin
                    if (m_depth_r == 0) m_neg_r <= 1'b1;
                    else m_depth_r <= m_depth_r - 1;
                end
                m_word_r <= '0;
                m_wlen_r <= 0;
            end else begin
                m_word_r <= {m_word_r[31:0], bus.chk_char};
                m_wlen_r <= m_wlen_r + 1;
            end
        end
    end

    always_comb begin
        m_pb = (m_wlen_r == 5) && (m_word_r == "begin");
        m_pe = (m_wlen_r == 3) && (m_word_r[23:0] == "end");
        bus.chk_result = !m_neg_r && !(m_pe && m_depth_r == 0) &&
                         (m_depth_r + int'(m_pb) - int'(m_pe) == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready),  32'd0);
        check({tag, "_chk_valid"},  32'(bus.chk_valid),  32'd0);
        check({tag, "_chk_clear"},  32'(bus.chk_clear),  32'd0);
        check({tag, "_chk_char"},   32'(bus.chk_char),   32'd0);
        check({tag, "_busy"},       32'(bus.busy),       32'd0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_id"},    32'(bus.resp_id),    32'd0);
        check({tag, "_resp_ok"},    32'(bus.resp_ok),    32'd0);
        check({tag, "_resp_len"},   32'(bus.resp_len),   32'd0);
    endtask

    // Requester driver: presents chars, optional stall gap, optional early stop.
    task automatic send(input int id, input string s, input int stall_at,
                        input int stall_len, input int stop_after);
        int i = 0;
        int t;
        @(posedge clk);
        #1;
        while (i < s.len()) begin
            if (i == stop_after) break;
            if (i == stall_at) begin
                bus.req_valid[id] = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_chk_valid", 32'(bus.chk_valid), 32'd0);
                    check("stall_busy", 32'(bus.busy), 32'd1);
                    @(posedge clk);
                    #1;
                end
            end
            bus.req_valid[id]        = 1'b1;
            bus.req_char[8*id +: 8]  = s[i];
            bus.req_last[id]         = (i == s.len() - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.req_ready[id] && t < 300);
            if (!bus.req_ready[id]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: requester %0d char %0d not accepted in %0d cycles", id, i, t);
                break;
            end
            if (i == s.len() - 1) last_acc[id] = cyc;
            @(posedge clk);
            #1;
            i++;
        end
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
    endtask

    task automatic expect_msg(input int id, input string s, input bit ok, input int len);
        resp_t e;
        for (int k = 0; k < s.len(); k++) chk_q.push_back(s[k]);
        e.id = id;
        e.ok = ok;
        e.len = len;
        resp_q.push_back(e);
    endtask

    // Monitor for the main instance.
    initial begin
        resp_t e;
        byte   c;
        forever begin
            @(negedge clk);
            if ($countones(bus.req_ready) > 1) overlaps++;
            if (bus.chk_clear) clears++;
            if (bus.chk_valid) begin
                if (chk_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_chk_valid: char=%0h with nothing expected", bus.chk_char);
                end else begin
                    c = chk_q.pop_front();
                    check("chk_char", 32'(bus.chk_char), 32'(c));
                end
            end
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: id=%0d len=%0d with nothing expected", bus.resp_id, bus.resp_len);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_id",      32'(bus.resp_id),  32'(e.id));
                    check("resp_ok",      32'(bus.resp_ok),  32'(e.ok));
                    check("resp_len",     32'(bus.resp_len), 32'(e.len));
                    check("resp_latency", 32'(cyc - last_acc[e.id]), 32'd2);
                    check("clear_count",  32'(clears), 32'd1);
                    clears = 0;
                end
            end
        end
    end

    // Monitor for the narrow-length instance.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus2.resp_valid) begin
                if (resp2_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp2: len=%0d", bus2.resp_len);
                end else begin
                    e = resp2_q.pop_front();
                    check("ovf_resp_id",  32'(bus2.resp_id),  32'(e.id));
                    check("ovf_resp_ok",  32'(bus2.resp_ok),  32'(e.ok));
                    check("ovf_resp_len", 32'(bus2.resp_len), 32'(e.len));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t e2;
        int    t;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_char  = '0;
        bus.req_last  = '0;
        bus2.req_valid = '0;
        bus2.req_char  = '0;
        bus2.req_last  = '0;
        bus2.chk_result = 1'b1;
        foreach (last_acc[k]) last_acc[k] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle_checks("reset");
        reset = 1'b0;

        // Single balanced message from requester 0.
        expect_msg(0, "begin end", 1'b1, 9);
        send(0, "begin end", -1, 0, -1);
        repeat (4) @(negedge clk);
        check("hold_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("hold_resp_len",   32'(bus.resp_len),   32'd9);
        check("hold_resp_ok",    32'(bus.resp_ok),    32'd1);
        check("hold_busy",       32'(bus.busy),       32'd0);

        // Unbalanced message from requester 3 (pointer then wraps to 0).
        expect_msg(3, "end begin", 1'b0, 9);
        send(3, "end begin", -1, 0, -1);

        // Contention 1 and 3 with pointer 0: 1 first.
        expect_msg(1, "begin end", 1'b1, 9);
        expect_msg(3, "x", 1'b1, 1);
        fork
            send(1, "begin end", -1, 0, -1);
            send(3, "x", -1, 0, -1);
        join

        // Contention 2 and 0 with pointer back at 0: 0 first.
        expect_msg(0, "end", 1'b0, 3);
        expect_msg(2, "begin end", 1'b1, 9);
        fork
            send(2, "begin end", -1, 0, -1);
            send(0, "end", -1, 0, -1);
        join

        // Stall mid-message for 5 cycles.
        expect_msg(1, "begin begin end end", 1'b1, 19);
        send(1, "begin begin end end", 6, 5, -1);

        // Minimum one-char message.
        expect_msg(2, "a", 1'b1, 1);
        send(2, "a", -1, 0, -1);

        // Reset after 4 accepted chars: no verdict expected.
        for (int k = 0; k < 4; k++) begin
            string sa = "begin end";
            chk_q.push_back(sa[k]);
        end
        send(2, "begin end", -1, 0, 4);
        #2 reset = 1'b1;
        @(negedge clk);
        idle_checks("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clears = 0;

        // Fresh message after reset starts with CLEAR and a zero length.
        expect_msg(2, "ab", 1'b1, 2);
        send(2, "ab", -1, 0, -1);

        // Overflow on a 3-bit length counter.
        e2.id = 0;
        e2.ok = 1'b0;
        e2.len = 7;
        resp2_q.push_back(e2);
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            bus2.req_valid[0]  = 1'b1;
            bus2.req_char[7:0] = msg2[i];
            bus2.req_last[0]   = (i == 8);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus2.req_ready[0] && t < 100);
            if (!bus2.req_ready[0]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ovf_accept_timeout: char %0d not accepted", i);
                break;
            end
            @(posedge clk);
            #1;
        end
        bus2.req_valid = '0;
        bus2.req_last  = '0;

        t = 0;
        while ((resp_q.size() != 0 || resp2_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("resp_q_drained",  32'(resp_q.size()),  32'd0);
        check("resp2_q_drained", 32'(resp2_q.size()), 32'd0);
        check("chk_q_drained",   32'(chk_q.size()),   32'd0);
        check("ready_onehot",    32'(overlaps),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
